// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a direct-mapped BTB with 2-bit saturating
// counters, looked up combinationally at fetch and trained at execute.
// Also keeps saturating counts of resolved branches and mispredictions.
module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCF,
  output logic                  predTakenF,
  output logic [ADDR_WIDTH-1:0] predTargetF,
  input  logic                  branchE,
  input  logic [ADDR_WIDTH-1:0] PCE,
  input  logic                  takenE,
  input  logic [ADDR_WIDTH-1:0] targetE,
  input  logic                  predTakenE,
  input  logic [ADDR_WIDTH-1:0] predTargetE,
  output logic                  mispredictE,
  output logic [ADDR_WIDTH-1:0] redirectPCE,
  output logic [CNT_WIDTH-1:0]  branchCount,
  output logic [CNT_WIDTH-1:0]  mispredictCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;

  // BTB storage, one slot per index
  logic                  validQ  [ENTRIES];
  logic [TAG_W-1:0]      tagQ    [ENTRIES];
  logic [1:0]            ctrQ    [ENTRIES];
  logic [ADDR_WIDTH-1:0] targetQ [ENTRIES];

  logic [CNT_WIDTH-1:0]  branchCountQ, branchCountD;
  logic [CNT_WIDTH-1:0]  mispredictCountQ, mispredictCountD;

  logic [INDEX_BITS-1:0] idxF, idxE;
  logic [TAG_W-1:0]      tagF, tagE;
  logic                  hitF, hitE;

  logic                  writeEn;
  logic                  validD;
  logic [TAG_W-1:0]      tagD;
  logic [1:0]            ctrD;
  logic [ADDR_WIDTH-1:0] targetD;

  // The two byte-offset bits of a word-aligned PC never reach the table
  logic unusedLowBits;
  assign unusedLowBits = ^{PCF[1:0], PCE[1:0]};

  assign idxF = PCF[INDEX_BITS+1:2];
  assign tagF = PCF[ADDR_WIDTH-1:INDEX_BITS+2];
  assign idxE = PCE[INDEX_BITS+1:2];
  assign tagE = PCE[ADDR_WIDTH-1:INDEX_BITS+2];

  // Fetch lookup reads the registered table, so a same-cycle update is not seen
  always_comb begin
    hitF        = validQ[idxF] && (tagQ[idxF] == tagF);
    predTakenF  = hitF && ctrQ[idxF][1];
    predTargetF = hitF ? targetQ[idxF] : '0;
  end

  // Resolve the execute-stage branch against the prediction that came down the pipe
  always_comb begin
    mispredictE = branchE &&
                  ((takenE != predTakenE) || (takenE && (targetE != predTargetE)));
    redirectPCE = takenE ? targetE : (PCE + ADDR_WIDTH'(4));
  end

  // Next contents of the entry addressed by PCE; only a taken miss allocates
  always_comb begin
    hitE    = validQ[idxE] && (tagQ[idxE] == tagE);
    writeEn = 1'b0;
    validD  = validQ[idxE];
    tagD    = tagQ[idxE];
    ctrD    = ctrQ[idxE];
    targetD = targetQ[idxE];
    if (branchE) begin
      if (hitE) begin
        writeEn = 1'b1;
        if (takenE) begin
          ctrD    = (ctrQ[idxE] == 2'b11) ? 2'b11 : ctrQ[idxE] + 2'd1;
          targetD = targetE;
        end else begin
          ctrD    = (ctrQ[idxE] == 2'b00) ? 2'b00 : ctrQ[idxE] - 2'd1;
        end
      end else if (takenE) begin
        writeEn = 1'b1;
        validD  = 1'b1;
        tagD    = tagE;
        ctrD    = 2'b10;
        targetD = targetE;
      end
    end
  end

  // Statistics advance once per resolved branch and stick at all-ones
  always_comb begin
    branchCountD     = branchCountQ;
    mispredictCountD = mispredictCountQ;
    if (branchE) begin
      if (branchCountQ != '1) begin
        branchCountD = branchCountQ + CNT_WIDTH'(1);
      end
      if (mispredictE && (mispredictCountQ != '1)) begin
        mispredictCountD = mispredictCountQ + CNT_WIDTH'(1);
      end
    end
  end

  // Table and statistics registers; reset wins over any same-cycle training
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        ctrQ[i]    <= 2'b01;
        targetQ[i] <= '0;
      end
      branchCountQ     <= '0;
      mispredictCountQ <= '0;
    end else begin
      if (writeEn) begin
        validQ[idxE]  <= validD;
        tagQ[idxE]    <= tagD;
        ctrQ[idxE]    <= ctrD;
        targetQ[idxE] <= targetD;
      end
      branchCountQ     <= branchCountD;
      mispredictCountQ <= mispredictCountD;
    end
  end

  assign branchCount     = branchCountQ;
  assign mispredictCount = mispredictCountQ;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a hand-computed vector table
// covering the directed corner cases, then random traffic compared against
// a behavioural model of the BTB.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic        branchE;
  logic [31:0] PCE;
  logic        takenE;
  logic [31:0] targetE;
  logic        predTakenE;
  logic [31:0] predTargetE;
  logic        mispredictE;
  logic [31:0] redirectPCE;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ADDR_WIDTH(32), .INDEX_BITS(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .predTakenF(predTakenF),
    .predTargetF(predTargetF), .branchE(branchE), .PCE(PCE), .takenE(takenE),
    .targetE(targetE), .predTakenE(predTakenE), .predTargetE(predTargetE),
    .mispredictE(mispredictE), .redirectPCE(redirectPCE),
    .branchCount(branchCount), .mispredictCount(mispredictCount)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic rst; logic [31:0] pcF; logic br; logic [31:0] pcE; logic tk;
    logic [31:0] tgt; logic pT; logic [31:0] pTgt;
    logic eTkF; logic [31:0] eTgtF; logic eMisp; logic [31:0] eRedir;
    logic [31:0] eBr; logic [31:0] eMp;
  } vec_t;

  // Behavioural model: each slot remembers a branch, a strength 0..3 and a target
  bit          mValid [16];
  logic [31:0] mTag   [16];
  int          mStr   [16];
  logic [31:0] mTgt   [16];
  logic [31:0] mBr, mMp;

  function automatic int slotOf(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [31:0] tagOf(logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit modelHit(logic [31:0] pc);
    return mValid[slotOf(pc)] && (mTag[slotOf(pc)] == tagOf(pc));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0; mTag[i] = 0; mStr[i] = 1; mTgt[i] = 0;
    end
    mBr = 0; mMp = 0;
  endtask

  task automatic modelStep(input logic r, input logic br, input logic [31:0] pcE,
                           input logic tk, input logic [31:0] tgt, input logic misp);
    int s;
    if (r) begin
      modelReset();
    end else if (br) begin
      if (mBr != 32'hFFFF_FFFF) mBr = mBr + 1;
      if (misp && mMp != 32'hFFFF_FFFF) mMp = mMp + 1;
      s = slotOf(pcE);
      if (modelHit(pcE)) begin
        if (tk) begin
          mStr[s] = (mStr[s] + 1 > 3) ? 3 : mStr[s] + 1;
          mTgt[s] = tgt;
        end else begin
          mStr[s] = (mStr[s] - 1 < 0) ? 0 : mStr[s] - 1;
        end
      end else if (tk) begin
        mValid[s] = 1; mTag[s] = tagOf(pcE); mStr[s] = 2; mTgt[s] = tgt;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; PCF = v.pcF; branchE = v.br; PCE = v.pcE; takenE = v.tk;
    targetE = v.tgt; predTakenE = v.pT; predTargetE = v.pTgt;
  endtask

  // Drive one cycle, check combinational outputs before the edge and counters after
  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v);
    #1;
    checkOutput({tag, " predTakenF"},  {31'b0, predTakenF},  {31'b0, v.eTkF});
    checkOutput({tag, " predTargetF"}, predTargetF,          v.eTgtF);
    checkOutput({tag, " mispredictE"}, {31'b0, mispredictE}, {31'b0, v.eMisp});
    checkOutput({tag, " redirectPCE"}, redirectPCE,          v.eRedir);
    @(posedge clk);
    #1;
    checkOutput({tag, " branchCount"},     branchCount,     v.eBr);
    checkOutput({tag, " mispredictCount"}, mispredictCount, v.eMp);
  endtask

  function automatic vec_t mk(logic r, logic [31:0] pcF, logic br, logic [31:0] pcE,
                              logic tk, logic [31:0] tgt, logic pT, logic [31:0] pTgt,
                              logic eTkF, logic [31:0] eTgtF, logic eMisp,
                              logic [31:0] eRedir, logic [31:0] eBr, logic [31:0] eMp);
    vec_t v;
    v.rst = r; v.pcF = pcF; v.br = br; v.pcE = pcE; v.tk = tk; v.tgt = tgt;
    v.pT = pT; v.pTgt = pTgt; v.eTkF = eTkF; v.eTgtF = eTgtF; v.eMisp = eMisp;
    v.eRedir = eRedir; v.eBr = eBr; v.eMp = eMp;
    return v;
  endfunction

  logic [31:0] tgtPool [4];

  initial begin
    vec_t vecs [21];
    vec_t v;
    logic [31:0] pcF, pcE, tgt, pTgt;
    logic tk, pT, br, r, eMisp;

    //            rst pcF           br pcE           tk tgt        pT pTgt       eTkF eTgtF     eMisp eRedir       eBr eMp
    vecs[0]  = mk(0, 32'h100,       0, 32'h0,        0, 32'h0,     0, 32'h0,     0, 32'h0,   0, 32'h4,        0, 0);
    vecs[1]  = mk(0, 32'h100,       1, 32'h100,      1, 32'h80,    0, 32'h0,     0, 32'h0,   1, 32'h80,       1, 1);
    vecs[2]  = mk(0, 32'h100,       1, 32'h100,      1, 32'h80,    1, 32'h80,    1, 32'h80,  0, 32'h80,       2, 1);
    vecs[3]  = mk(0, 32'h100,       1, 32'h100,      1, 32'h80,    1, 32'h80,    1, 32'h80,  0, 32'h80,       3, 1);
    vecs[4]  = mk(0, 32'h100,       1, 32'h100,      1, 32'h80,    1, 32'h80,    1, 32'h80,  0, 32'h80,       4, 1);
    vecs[5]  = mk(0, 32'h100,       1, 32'h100,      0, 32'h80,    1, 32'h80,    1, 32'h80,  1, 32'h104,      5, 2);
    vecs[6]  = mk(0, 32'h100,       0, 32'h0,        0, 32'h0,     0, 32'h0,     1, 32'h80,  0, 32'h4,        5, 2);
    vecs[7]  = mk(0, 32'h100,       1, 32'h100,      0, 32'h80,    1, 32'h80,    1, 32'h80,  1, 32'h104,      6, 3);
    vecs[8]  = mk(0, 32'h100,       0, 32'h0,        0, 32'h0,     0, 32'h0,     0, 32'h80,  0, 32'h4,        6, 3);
    vecs[9]  = mk(0, 32'h140,       1, 32'h140,      1, 32'h200,   0, 32'h0,     0, 32'h0,   1, 32'h200,      7, 4);
    vecs[10] = mk(0, 32'h100,       0, 32'h0,        0, 32'h0,     0, 32'h0,     0, 32'h0,   0, 32'h4,        7, 4);
    vecs[11] = mk(0, 32'h140,       0, 32'h0,        0, 32'h0,     0, 32'h0,     1, 32'h200, 0, 32'h4,        7, 4);
    vecs[12] = mk(0, 32'h140,       1, 32'h140,      1, 32'h210,   1, 32'h200,   1, 32'h200, 1, 32'h210,      8, 5);
    vecs[13] = mk(0, 32'h140,       0, 32'h0,        0, 32'h0,     0, 32'h0,     1, 32'h210, 0, 32'h4,        8, 5);
    vecs[14] = mk(0, 32'h300,       1, 32'h300,      0, 32'h0,     0, 32'h0,     0, 32'h0,   0, 32'h304,      9, 5);
    vecs[15] = mk(0, 32'h140,       0, 32'h0,        0, 32'h0,     0, 32'h0,     1, 32'h210, 0, 32'h4,        9, 5);
    vecs[16] = mk(1, 32'h140,       1, 32'h144,      1, 32'h400,   0, 32'h0,     1, 32'h210, 1, 32'h400,      0, 0);
    vecs[17] = mk(0, 32'h144,       0, 32'h0,        0, 32'h0,     0, 32'h0,     0, 32'h0,   0, 32'h4,        0, 0);
    vecs[18] = mk(0, 32'h140,       0, 32'h0,        0, 32'h0,     0, 32'h0,     0, 32'h0,   0, 32'h4,        0, 0);
    vecs[19] = mk(0, 32'h0,         1, 32'hFFFFFFFC, 0, 32'h0,     1, 32'h10,    0, 32'h0,   1, 32'h0,        1, 1);
    vecs[20] = mk(0, 32'hFFFFFFFC,  0, 32'h0,        0, 32'h0,     1, 32'h10,    0, 32'h0,   0, 32'h4,        1, 1);

    rst = 1'b1; PCF = 32'h100; branchE = 1'b0; PCE = '0; takenE = 1'b0;
    targetE = '0; predTakenE = 1'b0; predTargetE = '0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset applied");
    checkOutput("reset predTakenF",      {31'b0, predTakenF}, 32'h0);
    checkOutput("reset predTargetF",     predTargetF,         32'h0);
    checkOutput("reset branchCount",     branchCount,         32'h0);
    checkOutput("reset mispredictCount", mispredictCount,     32'h0);

    for (int i = 0; i < 21; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Randomised traffic against the model, starting from a fresh reset
    $display("[TB] random phase");
    tgtPool[0] = 32'h80; tgtPool[1] = 32'h90; tgtPool[2] = 32'h200; tgtPool[3] = 32'h210;
    v = mk(1, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
    applyStimulus(v);
    @(posedge clk);
    #1;
    modelReset();

    for (int n = 0; n < 600; n++) begin
      pcF  = ($urandom_range(0, 3) * 64) + ($urandom_range(0, 3) * 4);
      pcE  = ($urandom_range(0, 3) * 64) + ($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 99) == 0) pcE = 32'hFFFFFFFC;
      br   = ($urandom_range(0, 3) != 0);
      tk   = $urandom_range(0, 1);
      tgt  = tgtPool[$urandom_range(0, 3)];
      r    = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) < 7) begin
        pT   = modelHit(pcE) && (mStr[slotOf(pcE)] >= 2);
        pTgt = modelHit(pcE) ? mTgt[slotOf(pcE)] : 32'h0;
      end else begin
        pT   = $urandom_range(0, 1);
        pTgt = tgtPool[$urandom_range(0, 3)];
      end
      eMisp = br && ((tk != pT) || (tk && (tgt != pTgt)));

      v.rst = r; v.pcF = pcF; v.br = br; v.pcE = pcE; v.tk = tk; v.tgt = tgt;
      v.pT = pT; v.pTgt = pTgt;
      v.eTkF   = modelHit(pcF) && (mStr[slotOf(pcF)] >= 2);
      v.eTgtF  = modelHit(pcF) ? mTgt[slotOf(pcF)] : 32'h0;
      v.eMisp  = eMisp;
      v.eRedir = tk ? tgt : pcE + 32'd4;
      modelStep(r, br, pcE, tk, tgt, eMisp);
      v.eBr = mBr;
      v.eMp = mMp;
      runVector(v, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage pipeline.
- Fetch side: looks up PCF in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and supplies a predicted-taken flag and target to the PC mux.
- Execute side: compares the resolved branch outcome against the prediction carried down the pipe. It raises the mispredict indication that the hazard logic turns into a flush, and it trains the table.
- Keeps saturating statistics counters for branch count and mispredict count.

Parameters:
- ADDR_WIDTH, 32, width of PC and target addresses.
- INDEX_BITS, 4, log2 of BTB entries (16 entries); index = PC[INDEX_BITS+1:2].
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- PCF  in  ADDR_WIDTH  fetch-stage PC.
- predTakenF  out  1  prediction for PCF: taken.
- predTargetF  out  ADDR_WIDTH  predicted target; valid when predTakenF=1.
- branchE  in  1  execute-stage instruction is a conditional branch.
- PCE  in  ADDR_WIDTH  PC of execute-stage instruction.
- takenE  in  1  resolved outcome.
- targetE  in  ADDR_WIDTH  resolved branch target.
- predTakenE  in  1  prediction made at fetch, piped to E.
- predTargetE  in  ADDR_WIDTH  predicted target, piped to E.
- mispredictE  out  1  prediction wrong; flush F/D and redirect.
- redirectPCE  out  ADDR_WIDTH  correct next PC when mispredictE=1.
- branchCount  out  CNT_WIDTH  resolved branches since reset.
- mispredictCount  out  CNT_WIDTH  mispredictions since reset.

Behaviour:
- Reset (rst=1 at posedge):
  - All entries: valid=0, counter=2'b01.
  - branchCount and mispredictCount cleared to 0.
  - Combinational outputs follow their inputs. With rst asserted and all valid=0, predTakenF=0.
- Entry fields: valid, tag = PC[ADDR_WIDTH-1:INDEX_BITS+2], 2-bit counter, target.
- Lookup is combinational, zero latency:
  - hit = valid && tag match.
  - predTakenF = hit && counter[1].
  - predTargetF = entry target on a hit, else 0.
- Mispredict is combinational from the E inputs:
  - mispredictE = branchE && ((takenE != predTakenE) || (takenE && targetE != predTargetE)).
  - redirectPCE = takenE ? targetE : PCE+4. Wrap-around is modulo 2^ADDR_WIDTH.
  - When branchE=0: mispredictE=0 and no table update.
- Update happens at posedge when branchE=1, indexed by PCE:
  - Hit, taken: counter increments, saturating at 11; target <= targetE.
  - Hit, not taken: counter decrements, saturating at 00; target unchanged.
  - Miss, taken: allocate/replace the entry with valid=1, tag of PCE, counter=2'b10, target=targetE.
  - Miss, not taken: no change; no allocation.
- Simultaneous fetch lookup and E update to the same index: lookup returns the pre-update contents (read-before-write). The new state is visible from the next cycle.
- Statistics, on each branchE=1 cycle:
  - branchCount increments.
  - mispredictCount increments if mispredictE=1.
  - Both saturate at all-ones with no wrap.
- Reset mid-operation: rst overrides any same-cycle update; table and counters are reset and the update is dropped.
- No stall input. The E-stage inputs are driven by the pipeline register, which carries a bubble (branchE=0) during stalls/flushes. A branch held in E for multiple cycles is therefore the pipeline's responsibility, not this block's.

Test Plan:
- Reset then PCF=0x100 -> predTakenF=0, predTargetF=0; both counters=0.
- Branch E: PCE=0x100, takenE=1, targetE=0x080, predTakenE=0 -> mispredictE=1, redirectPCE=0x080, mispredictCount=1. Next cycle PCF=0x100 -> predTakenF=1, predTargetF=0x080.
- Same branch resolved taken 3 more times (predTakenE=1, predTargetE=0x080) -> mispredictE=0 each time; counter saturates at 11. Then one not-taken -> mispredictE=1, redirectPCE=0x104, predTakenF still 1 (counter 10). Second not-taken -> predTakenF=0.
- Aliasing: PCE=0x140 (same index as 0x100, different tag) resolved taken to 0x200 -> entry replaced; PCF=0x100 now misses (predTakenF=0), PCF=0x140 predicts 0x200.
- Same-cycle hazard: PCF=PCE=0x100 with an allocating update -> predTakenF=0 in that cycle, 1 in the next.
- Target change: hit with predTakenE=1, predTargetE=0x080, takenE=1, targetE=0x090 -> mispredictE=1, redirectPCE=0x090, entry target becomes 0x090. Also assert rst in the same cycle as an update -> the table stays cleared.
